// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - client and SRAM-controller signal bundle for sram_arbiter
interface sram_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16
) ();
    // requester side
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic [DATA_W-1:0]         rdata;

    // SRAM controller side
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_ready;
    logic                      mem_done;
    logic [DATA_W-1:0]         mem_rdata;

    // arbiter view
    modport slave (
        input  req, we, addr, wdata, mem_ready, mem_done, mem_rdata,
        output gnt, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    // environment view: requesters plus controller
    modport master (
        output req, we, addr, wdata, mem_ready, mem_done, mem_rdata,
        input  gnt, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter with burst retention and timeout for one SRAM port
module sram_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [BC_W-1:0]  BURST_MAX = BC_W'(MAX_BURST);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [BC_W-1:0]         burst_cnt_q, burst_cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;

    logic                    win_valid;
    logic [IDX_W-1:0]        win_idx;
    logic [BC_W-1:0]         win_burst;
    logic [TO_W-1:0]         to_inc;
    int                      cand;

    // The counter parks at its last value so a transaction accepted on the
    // final ISSUE cycle still times out on its first silent WAIT cycle.
    assign to_inc = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + 1'b1;

    // Winner selection; burst_cnt of zero means no owner yet, so after reset
    // the search starts at requester 0 instead of retaining NUM_REQ-1.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = owner_q;
        win_burst = BC_W'(1);
        cand      = 0;
        if (burst_cnt_q != '0 && burst_cnt_q < BURST_MAX && bus.req[owner_q]) begin
            win_valid = 1'b1;
            win_idx   = owner_q;
            win_burst = burst_cnt_q + 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = int'(owner_q) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!win_valid && bus.req[cand]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(cand);
                end
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT sequence.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        to_cnt_d    = to_cnt_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d          = S_ISSUE;
                    owner_d          = win_idx;
                    burst_cnt_d      = win_burst;
                    to_cnt_d         = '0;
                    gnt_d[win_idx]   = 1'b1;
                    mem_req_d        = 1'b1;
                    mem_we_d         = bus.we[win_idx];
                    mem_addr_d       = bus.addr[win_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d      = bus.wdata[win_idx*DATA_W +: DATA_W];
                end
            end
            S_ISSUE: begin
                if (bus.mem_ready) begin
                    state_d  = S_WAIT;
                    to_cnt_d = to_inc;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d         = S_IDLE;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    burst_cnt_d     = BURST_MAX;
                end else begin
                    mem_req_d = 1'b1;
                    to_cnt_d  = to_inc;
                end
            end
            S_WAIT: begin
                if (bus.mem_done) begin
                    state_d         = S_IDLE;
                    done_d[owner_q] = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d         = S_IDLE;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    burst_cnt_d     = BURST_MAX;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_RST;
            burst_cnt_q <= '0;
            to_cnt_q    <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
